// File: rtl/btn_pkg.sv
// Shared definitions for the multi-channel button debouncer: channel FSM encoding
// and the elaboration-time parameter legality check.
package btn_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PRESSED = 2'd1,
    ST_LONG    = 2'd2
  } btn_state_t;

  function automatic bit params_legal(input int n_ch, input int stable_cnt,
                                      input int long_ticks, input int repeat_ticks);
    return (n_ch >= 1) && (n_ch <= 16) &&
           (stable_cnt >= 1) && (stable_cnt <= 15) &&
           (long_ticks > stable_cnt) && (repeat_ticks >= 1);
  endfunction

endpackage

// File: rtl/multi_btn_debouncer_if.sv
// Button inputs and debounced event outputs of the debouncer, grouped as one bundle.
// master = button/control side, slave = debouncer side.
interface multi_btn_debouncer_if #(
  parameter int N_CH = 4
);
  logic [N_CH-1:0] btn;
  logic [N_CH-1:0] repeat_en;
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_pedge;
  logic [N_CH-1:0] btn_nedge;
  logic [N_CH-1:0] btn_long;
  logic [N_CH-1:0] btn_repeat;
  logic            sample_tick;

  modport master (
    output btn, repeat_en,
    input  btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat, sample_tick
  );

  modport slave (
    input  btn, repeat_en,
    output btn_level, btn_pedge, btn_nedge, btn_long, btn_repeat, sample_tick
  );
endinterface

// File: rtl/btn_channel.sv
// One button channel: 2-flop sync, tick-driven debounce, press/long/repeat FSM.
// Latency: events pulse one clk after the deciding tick; no backpressure (pulses only).
module btn_channel
  import btn_pkg::*;
#(
  parameter int STABLE_CNT    = 4,
  parameter int LONG_TICKS    = 256,
  parameter int REPEAT_TICKS  = 64,
  parameter bit ACTIVE_LOW_IN = 1'b0
) (
  input  logic clk,
  input  logic reset_n,
  input  logic tick,
  input  logic btn,
  input  logic repeat_en,
  output logic level,
  output logic pedge,
  output logic nedge,
  output logic long_press,
  output logic repeat_press
);
  localparam int HOLD_W = $clog2(LONG_TICKS + 1);
  localparam int REP_W  = $clog2(REPEAT_TICKS + 1);
  localparam logic [3:0]        STAB_LAST = 4'(STABLE_CNT - 1);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_TICKS - 1);
  localparam logic [HOLD_W-1:0] HOLD_MAX  = HOLD_W'(LONG_TICKS);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_TICKS - 1);

  logic [1:0]        sync;
  logic              sample;
  logic              flip;
  logic [3:0]        stab_cnt;
  btn_state_t        state, state_nx;
  logic [HOLD_W-1:0] hold, hold_nx;
  logic [REP_W-1:0]  rep, rep_nx;
  logic              long_nx, repeat_nx;

  assign sample = sync[1] ^ ACTIVE_LOW_IN;
  // flip marks the tick on which the debounced level changes
  assign flip   = tick && (sample != level) && (stab_cnt == STAB_LAST);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync     <= '0;
      stab_cnt <= '0;
      level    <= 1'b0;
      pedge    <= 1'b0;
      nedge    <= 1'b0;
    end else begin
      sync  <= {sync[0], btn};
      pedge <= flip & ~level;
      nedge <= flip & level;
      if (tick) begin
        if (sample == level) begin
          stab_cnt <= '0;
        end else if (flip) begin
          stab_cnt <= '0;
          level    <= ~level;
        end else begin
          stab_cnt <= stab_cnt + 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      hold         <= '0;
      rep          <= '0;
      long_press   <= 1'b0;
      repeat_press <= 1'b0;
    end else begin
      state        <= state_nx;
      hold         <= hold_nx;
      rep          <= rep_nx;
      long_press   <= long_nx;
      repeat_press <= repeat_nx;
    end
  end

  // A release flip takes priority over the long/repeat threshold on the same tick.
  always_comb begin
    state_nx  = state;
    hold_nx   = hold;
    rep_nx    = rep;
    long_nx   = 1'b0;
    repeat_nx = 1'b0;
    if (tick) begin
      unique case (state)
        ST_IDLE: begin
          if (flip && !level) begin
            state_nx = ST_PRESSED;
            hold_nx  = '0;
          end
        end
        ST_PRESSED: begin
          if (flip) begin
            state_nx = ST_IDLE;
            hold_nx  = '0;
            rep_nx   = '0;
          end else if (hold == HOLD_LAST) begin
            state_nx = ST_LONG;
            hold_nx  = HOLD_MAX;
            rep_nx   = '0;
            long_nx  = 1'b1;
          end else begin
            hold_nx = hold + 1'b1;
          end
        end
        ST_LONG: begin
          if (flip) begin
            state_nx = ST_IDLE;
            hold_nx  = '0;
            rep_nx   = '0;
          end else if (!repeat_en) begin
            rep_nx = '0;
          end else if (rep == REP_LAST) begin
            rep_nx    = '0;
            repeat_nx = 1'b1;
          end else begin
            rep_nx = rep + 1'b1;
          end
        end
        default: begin
          state_nx = ST_IDLE;
          hold_nx  = '0;
          rep_nx   = '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/multi_btn_debouncer.sv
// N_CH independent button debouncers sharing one free-running sample prescaler.
// Latency: 2 clk sync + STABLE_CNT ticks + 1 clk to pulse; no backpressure (pulses only).
module multi_btn_debouncer
  import btn_pkg::*;
#(
  parameter int N_CH          = 4,
  parameter int DIV_BITS      = 18,
  parameter int STABLE_CNT    = 4,
  parameter int LONG_TICKS    = 256,
  parameter int REPEAT_TICKS  = 64,
  parameter bit ACTIVE_LOW_IN = 1'b0
) (
  input  logic                   clk,
  input  logic                   reset_n,
  multi_btn_debouncer_if.slave   bus
);
  if (!params_legal(N_CH, STABLE_CNT, LONG_TICKS, REPEAT_TICKS)) begin : g_bad_params
    $error("multi_btn_debouncer: illegal parameter set");
  end

  logic [DIV_BITS-1:0] div_cnt;
  logic                tick;
  logic [N_CH-1:0]     level, pedge, nedge, long_p, repeat_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  assign tick = &div_cnt;

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    btn_channel #(
      .STABLE_CNT    (STABLE_CNT),
      .LONG_TICKS    (LONG_TICKS),
      .REPEAT_TICKS  (REPEAT_TICKS),
      .ACTIVE_LOW_IN (ACTIVE_LOW_IN)
    ) u_ch (
      .clk          (clk),
      .reset_n      (reset_n),
      .tick         (tick),
      .btn          (bus.btn[i]),
      .repeat_en    (bus.repeat_en[i]),
      .level        (level[i]),
      .pedge        (pedge[i]),
      .nedge        (nedge[i]),
      .long_press   (long_p[i]),
      .repeat_press (repeat_p[i])
    );
  end

  assign bus.btn_level   = level;
  assign bus.btn_pedge   = pedge;
  assign bus.btn_nedge   = nedge;
  assign bus.btn_long    = long_p;
  assign bus.btn_repeat  = repeat_p;
  assign bus.sample_tick = tick;

endmodule

// File: tb/tb_multi_btn_debouncer.sv
// Directed bench for multi_btn_debouncer (DIV_BITS=2, STABLE_CNT=3, LONG_TICKS=5, REPEAT_TICKS=2).
module tb_multi_btn_debouncer;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  multi_btn_debouncer_if #(.N_CH(4)) bus ();
  multi_btn_debouncer_if #(.N_CH(4)) bus_al ();

  multi_btn_debouncer #(
    .N_CH(4), .DIV_BITS(2), .STABLE_CNT(3), .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW_IN(1'b0)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  multi_btn_debouncer #(
    .N_CH(4), .DIV_BITS(2), .STABLE_CNT(3), .LONG_TICKS(5), .REPEAT_TICKS(2), .ACTIVE_LOW_IN(1'b1)
  ) dut_al (
    .clk(clk), .reset_n(reset_n), .bus(bus_al)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int n_al     = 0;
  int n_pe[4], n_ne[4], n_lg[4], n_rp[4], n_lv[4];
  int t_pe[4], t_ne[4], t_lg[4], t_rp[4], t_rp0[4];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic clear();
    for (int i = 0; i < 4; i++) begin
      n_pe[i] = 0; n_ne[i] = 0; n_lg[i] = 0; n_rp[i] = 0; n_lv[i] = 0;
      t_pe[i] = -1; t_ne[i] = -1; t_lg[i] = -1; t_rp[i] = -1; t_rp0[i] = -1;
    end
  endtask

  // One clock: sample outputs on the falling edge and log every event with its cycle.
  task automatic step();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < 4; i++) begin
      if (bus.btn_pedge[i]) begin n_pe[i]++; t_pe[i] = cyc; end
      if (bus.btn_nedge[i]) begin n_ne[i]++; t_ne[i] = cyc; end
      if (bus.btn_long[i])  begin n_lg[i]++; t_lg[i] = cyc; end
      if (bus.btn_repeat[i]) begin
        if (n_rp[i] == 0) t_rp0[i] = cyc;
        n_rp[i]++;
        t_rp[i] = cyc;
      end
      if (bus.btn_level[i]) n_lv[i]++;
    end
    if ((bus_al.btn_level | bus_al.btn_pedge | bus_al.btn_nedge |
         bus_al.btn_long | bus_al.btn_repeat) != 4'd0) n_al++;
  endtask

  // Stop on a cycle where sample_tick is visible, so the next edge applies it.
  task automatic align();
    int k;
    k = 0;
    step();
    while (!bus.sample_tick && k < 8) begin
      step();
      k++;
    end
    check("align_tick", int'(bus.sample_tick), 1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int d, r;
    reset_n       = 1'b0;
    bus.btn       = '0;
    bus.repeat_en = '0;
    bus_al.btn       = '1;
    bus_al.repeat_en = '1;
    clear();
    repeat (3) step();
    check("rst_level",  int'(bus.btn_level), 0);
    check("rst_pedge",  int'(bus.btn_pedge), 0);
    check("rst_nedge",  int'(bus.btn_nedge), 0);
    check("rst_long",   int'(bus.btn_long), 0);
    check("rst_repeat", int'(bus.btn_repeat), 0);
    check("rst_tick",   int'(bus.sample_tick), 0);
    reset_n = 1'b1;
    repeat (4) step();
    clear();

    // Steady press on channel 0
    align(); d = cyc; bus.btn[0] = 1'b1;
    repeat (20) step();
    check("s1_pedge_cnt", n_pe[0], 1);
    check("s1_pedge_lat", t_pe[0] - d, 13);
    check("s1_level", int'(bus.btn_level), 1);
    check("s1_other_pedge", n_pe[1] + n_pe[2] + n_pe[3], 0);
    bus.btn[0] = 1'b0;
    repeat (40) step();
    clear();

    // Chatter on channel 1: toggle every 3 clk for 40 clk
    for (int k = 0; k < 40; k++) begin
      if (k % 3 == 0) bus.btn[1] = ~bus.btn[1];
      step();
    end
    bus.btn[1] = 1'b0;
    repeat (20) step();
    check("s2_level_cycles", n_lv[1], 0);
    check("s2_pedge_cnt", n_pe[1], 0);
    check("s2_nedge_cnt", n_ne[1], 0);
    clear();

    // Long press with auto-repeat on channel 2
    bus.repeat_en[2] = 1'b1;
    align(); d = cyc; bus.btn[2] = 1'b1;
    repeat (50) step();
    check("s3_pedge_lat", t_pe[2] - d, 13);
    check("s3_long_cnt", n_lg[2], 1);
    check("s3_long_lat", t_lg[2] - d, 33);
    check("s3_rep_cnt", n_rp[2], 2);
    check("s3_rep_first", t_rp0[2] - d, 41);
    check("s3_rep_last", t_rp[2] - d, 49);
    bus.btn[2] = 1'b0;
    repeat (30) step();
    clear();

    // Long press without auto-repeat on channel 2
    bus.repeat_en[2] = 1'b0;
    align(); d = cyc; bus.btn[2] = 1'b1;
    repeat (60) step();
    check("s3b_long_cnt", n_lg[2], 1);
    check("s3b_long_lat", t_lg[2] - d, 33);
    check("s3b_rep_cnt", n_rp[2], 0);
    bus.btn[2] = 1'b0;
    repeat (30) step();
    clear();

    // Channel 3: release debounce lands on the LONG_TICKS tick
    align(); d = cyc; bus.btn[3] = 1'b1;
    repeat (20) step();
    bus.btn[3] = 1'b0;
    repeat (20) step();
    check("s4_pedge_cnt", n_pe[3], 1);
    check("s4_nedge_cnt", n_ne[3], 1);
    check("s4_nedge_lat", t_ne[3] - d, 33);
    check("s4_long_cnt", n_lg[3], 0);
    check("s4_level", int'(bus.btn_level), 0);
    clear();

    // All channels pressed together, then reset while in LONG
    bus.repeat_en = '0;
    align(); d = cyc; bus.btn = 4'hF;
    repeat (36) step();
    for (int i = 0; i < 4; i++) begin
      check($sformatf("s5_pedge_lat%0d", i), t_pe[i] - d, 13);
      check($sformatf("s5_long_lat%0d", i), t_lg[i] - d, 33);
    end
    check("s5_level", int'(bus.btn_level), 15);
    reset_n = 1'b0;
    #1;
    check("s5_async_level", int'(bus.btn_level), 0);
    check("s5_async_edges", int'(bus.btn_pedge | bus.btn_nedge), 0);
    check("s5_async_long_rep", int'(bus.btn_long | bus.btn_repeat), 0);
    check("s5_async_tick", int'(bus.sample_tick), 0);
    clear();
    repeat (3) step();
    reset_n = 1'b1;
    r = cyc;
    repeat (14) step();
    check("s5_post_pedge_cnt", n_pe[0] + n_pe[1] + n_pe[2] + n_pe[3], 4);
    check("s5_post_pedge_lat0", t_pe[0] - r, 12);
    check("s5_post_pedge_lat3", t_pe[3] - r, 12);
    check("s5_post_level", int'(bus.btn_level), 15);

    // Inverted-input instance held all-ones for the whole run
    check("al_events", n_al, 0);
    check("al_level", int'(bus_al.btn_level), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
